max_pool_2x2: RTL

MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

---
 rtl/npu_pkg.sv | 13 +
 rtl/pool_line_buffer.sv | 27 ++
 rtl/max_pool_2x2.sv | 92 +++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared pixel types for the NPU activation and pooling stages
package npu_pkg;

    localparam int PIX_W = 22;

    typedef logic signed [PIX_W-1:0] pixel_t;

    // Signed maximum; both operands are pixel_t so the compare is two's-complement.
    function automatic pixel_t pixel_max(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// rtl/pool_line_buffer.sv - half-line store of horizontal pair maxima for 2x2 pooling
module pool_line_buffer
    import npu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pixel_t        wr_data,
    input  logic [AW-1:0] rd_addr,
    output pixel_t        rd_data
);

    // No reset: every entry is rewritten on an even row before an odd row reads it.
    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/max_pool_2x2.sv
// rtl/max_pool_2x2.sv - streaming 2x2 stride-2 signed max pooling over a raster frame
module max_pool_2x2
    import npu_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   pixel_valid,
    input  pixel_t pixel_in,
    output logic   result_valid,
    output pixel_t result_out,
    output logic   frame_done
);

    localparam int COL_W    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int ROW_W    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    pixel_t           h;

    logic             accept;
    logic             col_odd;
    logic             row_odd;
    logic             col_last;
    logic             row_last;
    logic             lb_wr_en;
    logic [LB_AW-1:0] lb_addr;
    pixel_t           lb_rd_data;
    pixel_t           pair_max;

    assign accept   = rst & pixel_valid;
    assign col_odd  = col[0];
    assign row_odd  = row[0];
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign lb_addr  = LB_AW'(col >> 1);
    assign pair_max = pixel_max(h, pixel_in);

    // Even rows deposit the top-pair maximum; odd rows consume it.
    assign lb_wr_en = accept & col_odd & ~row_odd;

    pool_line_buffer #(
        .DEPTH (LB_DEPTH),
        .AW    (LB_AW)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .wr_addr (lb_addr),
        .wr_data (pair_max),
        .rd_addr (lb_addr),
        .rd_data (lb_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            col          <= '0;
            row          <= '0;
            h            <= '0;
            result_valid <= 1'b0;
            frame_done   <= 1'b0;
            result_out   <= '0;
        end else begin
            result_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (pixel_valid) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                if (!col_odd) begin
                    h <= pixel_in;
                end else if (row_odd) begin
                    result_out   <= pixel_max(lb_rd_data, pair_max);
                    result_valid <= 1'b1;
                    frame_done   <= col_last & row_last;
                end
            end
        end
    end

endmodule
